// File: rtl/connect4_pkg.sv
// Shared definitions for the 4x4 Connect4 board engine and its detector:
// status codes, engine states and board geometry.
package connect4_pkg;

    localparam int BOARD_BITS   = 16;
    localparam int ROW_STRIDE   = 4;
    localparam int TOP_ROW_BASE = 12;

    localparam logic [BOARD_BITS-1:0] BOTTOM_ROW_MASK = 16'h000F;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } game_status_e;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        LAND,
        SETTLE
    } state_e;

    // One-hot top-row cell of a column; column c is bits {12+c, 8+c, 4+c, c}.
    function automatic logic [BOARD_BITS-1:0] top_cell(input logic [1:0] col);
        top_cell = BOARD_BITS'(1) << (TOP_ROW_BASE + int'(col));
    endfunction

endpackage

// File: rtl/board_writer_drop_timer.sv
// Modulo-N cycle counter with synchronous clear; o_terminal flags the last
// count of each period while enabled.
module drop_timer #(
    parameter int N = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_count;

    assign o_terminal = i_enable && (r_count == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_terminal ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/board_writer.sv
// Connect4 move engine: accepts column moves, animates the falling piece one
// row per DROP_CYCLES, commits it to the board and alternates players.
module board_writer
    import connect4_pkg::*;
#(
    parameter int DROP_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [1:0]  move_col,
    input  logic [1:0]  game_status,
    output logic        move_ready,
    output logic [15:0] game_board,
    output logic [15:0] player_cells,
    output logic        current_player,
    output logic [15:0] falling_cell,
    output logic        move_done,
    output logic        move_error
);

    state_e      r_state, w_state_nxt;
    logic [15:0] r_board, w_board_nxt;
    logic [15:0] r_cells, w_cells_nxt;
    logic [15:0] r_falling, w_falling_nxt;
    logic        r_player, w_player_nxt;
    logic        r_done, w_done_nxt;
    logic        r_error, w_error_nxt;

    logic w_drop_en, w_settle_en, w_drop_tc, w_settle_tc;
    logic [15:0] w_below;

    assign move_ready  = (r_state == IDLE) && (game_status == STILL_PLAYING);
    assign w_drop_en   = (r_state == FALL);
    assign w_settle_en = (r_state == SETTLE);
    assign w_below     = r_falling >> ROW_STRIDE;

    drop_timer #(.N(DROP_CYCLES)) u_drop_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_clear    (new_game || !w_drop_en),
        .i_enable   (w_drop_en),
        .o_terminal (w_drop_tc)
    );

    drop_timer #(.N(SETTLE_CYCLES)) u_settle_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_clear    (new_game || !w_settle_en),
        .i_enable   (w_settle_en),
        .o_terminal (w_settle_tc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_board_nxt   = r_board;
        w_cells_nxt   = r_cells;
        w_falling_nxt = r_falling;
        w_player_nxt  = r_player;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;

        if (new_game) begin
            w_state_nxt   = IDLE;
            w_board_nxt   = '0;
            w_cells_nxt   = '0;
            w_falling_nxt = '0;
            w_player_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (move_valid && move_ready) begin
                        if ((r_board & top_cell(move_col)) != '0) begin
                            w_error_nxt = 1'b1;
                        end else begin
                            w_falling_nxt = top_cell(move_col);
                            w_state_nxt   = FALL;
                        end
                    end
                end
                FALL: begin
                    if (w_drop_tc) begin
                        // Descend only while a free cell exists directly below.
                        if ((r_falling & BOTTOM_ROW_MASK) == '0 && (r_board & w_below) == '0) begin
                            w_falling_nxt = w_below;
                        end else begin
                            w_state_nxt = LAND;
                        end
                    end
                end
                LAND: begin
                    w_board_nxt   = r_board | r_falling;
                    w_cells_nxt   = r_player ? (r_cells | r_falling) : r_cells;
                    w_falling_nxt = '0;
                    w_player_nxt  = ~r_player;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = SETTLE;
                end
                SETTLE: begin
                    if (w_settle_tc) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_board   <= '0;
            r_cells   <= '0;
            r_falling <= '0;
            r_player  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_board   <= w_board_nxt;
            r_cells   <= w_cells_nxt;
            r_falling <= w_falling_nxt;
            r_player  <= w_player_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign game_board     = r_board;
    assign player_cells   = r_cells;
    assign current_player = r_player;
    assign falling_cell   = r_falling;
    assign move_done      = r_done;
    assign move_error     = r_error;

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: drop animation, stacking, full column,
// game-over gating, new_game priority and asynchronous reset mid-fall.
module tb_board_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_col = 2'd0;
    logic [1:0]  game_status = 2'b00;
    logic        move_ready;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic        current_player;
    logic [15:0] falling_cell;
    logic        move_done;
    logic        move_error;

    int total = 0;
    int bad   = 0;
    logic [15:0] fall_log [0:63];

    board_writer #(.DROP_CYCLES(4), .SETTLE_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .new_game       (new_game),
        .move_valid     (move_valid),
        .move_col       (move_col),
        .game_status    (game_status),
        .move_ready     (move_ready),
        .game_board     (game_board),
        .player_cells   (player_cells),
        .current_player (current_player),
        .falling_cell   (falling_cell),
        .move_done      (move_done),
        .move_error     (move_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_inv();
        check("inv_owner", player_cells & ~game_board, 0);
        check("inv_falling", falling_cell & game_board, 0);
        check("inv_done_err", move_done & move_error, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!move_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", move_ready, 1);
    endtask

    task automatic do_move(input logic [1:0] col, input int exp_lat,
                           input logic [15:0] exp_board, input logic [15:0] exp_pc,
                           input logic exp_cp, input bit hold, input bit status_mid);
        int n;
        logic [15:0] board0;
        wait_ready();
        board0     = game_board;
        move_valid = 1'b1;
        move_col   = col;
        tick();
        if (!hold) move_valid = 1'b0;
        n = 0;
        fall_log[0] = falling_cell;
        while (!move_done && n < 60) begin
            if (status_mid && n == 2) game_status = 2'b11;
            check("board_before_done", game_board, board0);
            check_inv();
            tick();
            n++;
            fall_log[n] = falling_cell;
        end
        check("latency", n, exp_lat);
        check("board", game_board, exp_board);
        check("player_cells", player_cells, exp_pc);
        check("current_player", current_player, exp_cp);
        check("falling_cleared", falling_cell, 0);
        check("no_error", move_error, 0);
        check_inv();
        if (hold) begin
            tick();
            check("done_one_cycle", move_done, 0);
            tick();
            move_valid = 1'b0;
        end
        game_status = 2'b00;
    endtask

    logic [1:0]  seq_col   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    int          seq_lat   [8] = '{17, 17, 17, 17, 13, 13, 13, 13};
    logic [15:0] seq_board [8] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F,
                                   16'h001F, 16'h003F, 16'h007F, 16'h00FF};
    logic [15:0] seq_pc    [8] = '{16'h0000, 16'h0002, 16'h0002, 16'h000A,
                                   16'h000A, 16'h002A, 16'h002A, 16'h00AA};
    logic        seq_cp    [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int cnt_done;
        int cnt_err;
        int n;

        // Reset state.
        #3;
        check("rst_board", game_board, 0);
        check("rst_cells", player_cells, 0);
        check("rst_player", current_player, 0);
        check("rst_falling", falling_cell, 0);
        check("rst_done", move_done, 0);
        check("rst_error", move_error, 0);
        check("rst_ready", move_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // First move: full drop down column 0, animation profile.
        do_move(2'd0, 17, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("fall_c0", fall_log[0], 16'h1000);
        check("fall_c3", fall_log[3], 16'h1000);
        check("fall_c4", fall_log[4], 16'h0100);
        check("fall_c7", fall_log[7], 16'h0100);
        check("fall_c8", fall_log[8], 16'h0010);
        check("fall_c12", fall_log[12], 16'h0001);
        check("fall_c16", fall_log[16], 16'h0001);

        // Second move stacks on top, owned by player 2.
        do_move(2'd0, 13, 16'h0011, 16'h0010, 1'b0, 1'b0, 1'b0);
        do_move(2'd3, 17, 16'h0019, 16'h0010, 1'b1, 1'b0, 1'b0);

        // new_game together with a move: new_game wins.
        wait_ready();
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_col   = 2'd1;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        check("ng_board", game_board, 0);
        check("ng_cells", player_cells, 0);
        check("ng_player", current_player, 0);
        check("ng_falling", falling_cell, 0);
        cnt_done = 0;
        repeat (25) begin
            tick();
            cnt_done += int'(move_done);
            if (falling_cell != 0) cnt_done += 100;
        end
        check("ng_move_dropped", cnt_done, 0);

        // Fill column 2; the first move holds move_valid through FALL/SETTLE.
        do_move(2'd2, 17, 16'h0004, 16'h0000, 1'b1, 1'b1, 1'b0);
        cnt_done = 0;
        repeat (20) begin
            tick();
            cnt_done += int'(move_done);
        end
        check("held_valid_single_done", cnt_done, 0);
        check("held_valid_board", game_board, 16'h0004);
        do_move(2'd2, 13, 16'h0044, 16'h0040, 1'b0, 1'b0, 1'b0);
        do_move(2'd2, 9,  16'h0444, 16'h0040, 1'b1, 1'b0, 1'b0);
        do_move(2'd2, 5,  16'h4444, 16'h4040, 1'b0, 1'b0, 1'b0);

        // Fifth move into the full column.
        wait_ready();
        move_valid = 1'b1;
        move_col   = 2'd2;
        tick();
        move_valid = 1'b0;
        check("full_error", move_error, 1);
        check("full_no_done", move_done, 0);
        tick();
        check("full_error_pulse", move_error, 0);
        cnt_done = 0;
        cnt_err  = 0;
        repeat (20) begin
            tick();
            cnt_done += int'(move_done);
            cnt_err  += int'(move_error);
        end
        check("full_dones", cnt_done, 0);
        check("full_errs", cnt_err, 0);
        check("full_board", game_board, 16'h4444);
        check("full_cells", player_cells, 16'h4040);
        check("full_player", current_player, 0);

        // Game over: moves are refused.
        game_status = 2'b01;
        tick();
        check("over_ready", move_ready, 0);
        move_valid = 1'b1;
        move_col   = 2'd0;
        cnt_done   = 0;
        repeat (10) begin
            tick();
            cnt_done += int'(move_done);
            if (falling_cell != 0) cnt_done += 100;
        end
        move_valid = 1'b0;
        check("over_no_move", cnt_done, 0);
        check("over_board", game_board, 16'h4444);
        game_status = 2'b00;
        #1;
        check("resume_ready", move_ready, 1);

        // Fill the bottom two rows, with a status change mid-fall on one move.
        tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_move(seq_col[i], seq_lat[i], seq_board[i], seq_pc[i], seq_cp[i], 1'b0, i == 2);
        end
        wait_ready();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("ng2_board", game_board, 0);
        check("ng2_cells", player_cells, 0);
        check("ng2_player", current_player, 0);

        // Asynchronous reset while the piece is in row 1 of column 0.
        wait_ready();
        move_valid = 1'b1;
        move_col   = 2'd0;
        tick();
        move_valid = 1'b0;
        n = 0;
        while (falling_cell != 16'h0100 && n < 40) begin
            tick();
            n++;
        end
        check("pre_reset_falling", falling_cell, 16'h0100);
        #2;
        reset = 1'b0;
        #1;
        check("arst_falling", falling_cell, 0);
        check("arst_board", game_board, 0);
        check("arst_done", move_done, 0);
        check("arst_player", current_player, 0);
        @(negedge clk);
        reset = 1'b1;
        cnt_done = 0;
        repeat (25) begin
            tick();
            cnt_done += int'(move_done);
        end
        check("arst_no_write", cnt_done, 0);
        check("arst_board_after", game_board, 0);
        check("arst_ready_after", move_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
Move engine that produces the 4x4 Connect4 board consumed by the winner detector. It owns two 16-bit words: game_board (occupancy) and player_cells (ownership: 0 = player 1, 1 = player 2). It accepts column moves through a valid/ready handshake and animates the piece falling under gravity, one row every DROP_CYCLES. It commits the piece and alternates players, and it stops accepting moves once the detector reports a result.

Parameters:
DROP_CYCLES, 4, clock cycles the falling piece spends in each row (>=1)
SETTLE_CYCLES, 2, cycles waited after a commit so the detector's game_status is current (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
new_game  input  1  synchronous clear of board and player; wins over all but reset
move_valid  input  1  move request, level; sampled only while move_ready=1
move_col  input  2  column 0..3; column c = bits {12+c, 8+c, 4+c, c}, top to bottom
game_status  input  2  from detector: 00 playing, 01 p1 wins, 10 p2 wins, 11 tie
move_ready  output  1  engine idle and game_status==00
game_board  output  16  occupancy; bits 15..12 = top row, 3..0 = bottom row
player_cells  output  16  owner of each occupied bit; 0 where unoccupied
current_player  output  1  0 = player 1 to move, 1 = player 2
falling_cell  output  16  one-hot position of the animated piece; 0 when none
move_done  output  1  one-cycle pulse; the new board is visible in this cycle
move_error  output  1  one-cycle pulse; the move was rejected because the column is full

Behaviour:
- Reset (reset=0, async): board, player_cells, falling_cell = 0; current_player=0; move_done, move_error = 0; state IDLE. The same values are loaded synchronously on new_game=1.
- States:
  - IDLE: move_ready = (game_status==00).
    - Accept when move_valid && move_ready at a clock edge.
    - Column full (bit 12+col set): move_error=1 for the next cycle, stay IDLE, board unchanged.
    - Otherwise: falling_cell = 1<<(12+col), drop counter = 0, go FALL.
  - FALL: counter counts 0..DROP_CYCLES-1.
    - At DROP_CYCLES-1, if the piece is not in the bottom row and the cell 4 bits lower is empty: falling_cell >>= 4, counter = 0.
    - Else go LAND.
  - LAND: game_board |= falling_cell; the player_cells bit gets current_player; falling_cell = 0; current_player toggles; move_done=1 registered with the write; go SETTLE.
  - SETTLE: count SETTLE_CYCLES, then IDLE. move_ready=0 throughout.
- Latency: a piece landing in row r (0 = top) spends (r+1)*DROP_CYCLES cycles in FALL. The board and move_done appear (r+1)*DROP_CYCLES+1 cycles after the accepting edge.
- Invariants:
  - player_cells & ~game_board == 0.
  - The occupied cells of each column are contiguous from the bottom.
  - falling_cell is never an occupied bit.
- move_valid outside IDLE, or with game_status!=00, is ignored and not queued.
- game_status changing mid-FALL does not abort the fall; the piece still commits.
- Async reset mid-FALL: falling_cell is 0 immediately and no partial write occurs.
- new_game and move_valid in the same cycle: new_game wins and the move is dropped.
- move_done and move_error are never high together.

Decomposition:
- Package connect4_pkg holds:
  - game_status codes STILL_PLAYING/P1_WINS/P2_WINS/TIE
  - state enum IDLE/FALL/LAND/SETTLE
  - BOARD_BITS=16, ROW_STRIDE=4, TOP_ROW_BASE=12
- One sub-module, drop_timer: a parameterised modulo-N counter with clear and terminal-count output, instantiated for both DROP_CYCLES and SETTLE_CYCLES.

Test Plan:
- Empty board, col 0, DROP_CYCLES=4 -> falling_cell 0x1000, 0x0100, 0x0010, 0x0001, 4 cycles each. Then game_board=0x0001, player_cells=0x0000, move_done pulse 17 cycles after accept, current_player=1.
- Second move col 0 -> lands on bit 4 after 13 cycles; game_board=0x0011, player_cells=0x0010, current_player=0.
- Four moves into col 2, then a fifth -> game_board=0x4444, player_cells=0x4040; fifth gives a move_error pulse, board unchanged, no move_done.
- game_status forced to 01 -> move_ready=0; move_valid held 10 cycles produces no change. Return to 00 -> move_ready=1 when in IDLE.
- reset low while falling_cell=0x0100 -> all outputs 0 asynchronously, state IDLE. new_game with board 0x00FF -> next cycle board=0, player_cells=0, current_player=0.
- move_valid asserted during FALL and SETTLE -> ignored; exactly one move_done per accepted move.
